// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned A - B using one full-subtractor cell, LSB first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
   parameter  int WIDTH = 4,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bin;

   logic w_a;
   logic w_b;
   logic w_d;
   logic w_bout;
   logic w_last;

   // Full-subtractor cell operating on the current LSBs of the operand shifters
   assign w_a    = r_a[0];
   assign w_b    = r_b[0];
   assign w_d    = w_a ^ w_b ^ r_bin;
   assign w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & r_bin);
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_bin   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         diff    <= '0;
         borrow  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf     <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            // DONE accepts start exactly like IDLE so back-to-back runs lose no cycle
            S_IDLE, S_DONE: begin
               busy <= 1'b0;
               if (start) begin
                  r_a     <= A;
                  r_b     <= B;
                  r_res   <= '0;
                  r_cnt   <= '0;
                  r_bin   <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= S_SHIFT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_SHIFT: begin
               r_res <= {w_d, r_res[WIDTH-1:1]};
               r_a   <= r_a >> 1;
               r_b   <= r_b >> 1;
               r_bin <= w_bout;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  diff    <= {w_d, r_res[WIDTH-1:1]};
                  borrow  <= w_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  ovf     <= (w_a != w_b) && (w_d != w_a);
`endif
               end
            end
            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized scoreboard bench for serial_subtractor.
module tb_serial_subtractor;

   localparam int WIDTH = 4;
   localparam int MOD   = 1 << WIDTH;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;
`endif

   int n_cmp   = 0;
   int n_bad   = 0;
   int n_start = 0;
   int n_done  = 0;
   logic [WIDTH+1:0] exp_q[$];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Reference: {ovf, borrow, diff} from plain integer arithmetic
   function automatic logic [WIDTH+1:0] model(input int a, input int b);
      int d;
      int sa;
      int sb;
      int s;
      logic ov;
      logic bo;
      d  = (a - b + MOD) % MOD;
      sa = (a >= MOD / 2) ? a - MOD : a;
      sb = (b >= MOD / 2) ? b - MOD : b;
      s  = sa - sb;
      ov = (s > MOD / 2 - 1) || (s < -(MOD / 2));
      bo = (a < b);
      return {ov, bo, d[WIDTH-1:0]};
   endfunction

   task automatic push(input int a, input int b);
      exp_q.push_back(model(a, b));
      n_start++;
   endtask

   task automatic monitor();
      logic [WIDTH+1:0] e;
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1 want no pending operation");
            end else begin
               e = exp_q.pop_front();
               check("diff", int'(diff), int'(e[WIDTH-1:0]));
               check("borrow", int'(borrow), int'(e[WIDTH]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               check("ovf", int'(ovf), int'(e[WIDTH+1]));
`endif
            end
         end
      end
   endtask

   task automatic do_op(input int a, input int b);
      int lat;
      @(posedge clk);
      #1;
      A     = WIDTH'(a);
      B     = WIDTH'(b);
      start = 1'b1;
      @(posedge clk);
      push(a, b);
      #1;
      start = 1'b0;
      A     = WIDTH'($urandom_range(0, MOD - 1));
      B     = WIDTH'($urandom_range(0, MOD - 1));
      check("busy_after_accept", int'(busy), 1);
      lat = 0;
      for (int i = 1; i <= WIDTH + 4; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, WIDTH);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_diff", int'(diff), 0);
      check("rst_borrow", int'(borrow), 0);
      rst = 1'b0;

      do_op(9, 4);
      do_op(2, 7);
      do_op(5, 5);
      do_op(0, 15);

      // Back-to-back with start held high; operands scrambled during SHIFT
      start = 1'b1;
      A     = 4'd15;
      B     = 4'd1;
      for (int rep = 0; rep < 4; rep++) begin
         @(posedge clk);
         push(15, 1);
         #1;
         check("b2b_busy", int'(busy), 1);
         A = WIDTH'($urandom_range(0, MOD - 1));
         B = WIDTH'($urandom_range(0, MOD - 1));
         repeat (3) @(posedge clk);
         #1;
         check("b2b_not_done_early", int'(done), 0);
         A = 4'd15;
         B = 4'd1;
         @(posedge clk);
         #1;
         check("b2b_done", int'(done), 1);
         if (rep == 3) start = 1'b0;
      end

      // Asynchronous reset in the middle of the second SHIFT cycle
      @(posedge clk);
      #1;
      A     = 4'd12;
      B     = 4'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_diff", int'(diff), 0);
      check("abort_borrow", int'(borrow), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (WIDTH + 2) @(posedge clk);
      do_op(12, 3);

      for (int a = 0; a < MOD; a++)
         for (int b = 0; b < MOD; b++)
            do_op(a, b);

      for (int i = 0; i < 40; i++)
         do_op(int'($urandom_range(0, MOD - 1)), int'($urandom_range(0, MOD - 1)));

      do_op(8, 1);
      do_op(7, 15);
      do_op(3, 1);

      repeat (WIDTH + 3) @(posedge clk);
      #1;
      check("done_per_start", n_done, n_start);
      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
